// File: rtl/mcycle_unit_pkg.sv
// mcycle_pkg: op codes, FSM state encodings and counter sizing shared by the
// multi-cycle multiply/divide unit, its interface and its testbench.
// Latency: n/a (declarations only). Backpressure: n/a.
// Contents: mc_op_t, mc_state_t, MC_WIDTH, MC_CNT_W, helper functions.
package mcycle_pkg;

  // Default operand width and iteration-counter width derived from it.
  localparam int MC_WIDTH = 32;
  localparam int MC_CNT_W = $clog2(MC_WIDTH);

  typedef enum logic [1:0] {
    MC_MULU = 2'b00,
    MC_MULS = 2'b01,
    MC_DIVU = 2'b10,
    MC_DIVS = 2'b11
  } mc_op_t;

  typedef enum logic [1:0] {
    MC_IDLE    = 2'd0,
    MC_COMPUTE = 2'd1,
    MC_DONE    = 2'd2
  } mc_state_t;

  // Counter width for an arbitrary WIDTH; never narrower than one bit.
  function automatic int mc_cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  function automatic logic mc_is_div(input mc_op_t op);
    return (op == MC_DIVU) || (op == MC_DIVS);
  endfunction

  function automatic logic mc_is_signed(input mc_op_t op);
    return (op == MC_MULS) || (op == MC_DIVS);
  endfunction

endpackage

// File: rtl/mcycle_unit_if.sv
// mcycle_unit_if: execute-stage start/result bundle for the multi-cycle unit.
// Latency: n/a (wires only). Backpressure: Busy is the stall towards the pipe.
// Ports: MStart/MCycleOp/Operand1/Operand2 from the stage (master),
//        Result1/Result2/Busy/Done from the unit (slave).
interface mcycle_unit_if
  import mcycle_pkg::*;
#(
  parameter int WIDTH = MC_WIDTH
);

  logic             MStart;
  mc_op_t           MCycleOp;
  logic [WIDTH-1:0] Operand1;
  logic [WIDTH-1:0] Operand2;
  logic [WIDTH-1:0] Result1;
  logic [WIDTH-1:0] Result2;
  logic             Busy;
  logic             Done;

  modport master (
    output MStart, MCycleOp, Operand1, Operand2,
    input  Result1, Result2, Busy, Done
  );

  modport slave (
    input  MStart, MCycleOp, Operand1, Operand2,
    output Result1, Result2, Busy, Done
  );

endinterface

// File: rtl/mcycle_unit_cond_negate.sv
// cond_negate: two's-complement i_val when i_neg is set, else pass through.
// Latency: combinational. Backpressure: none.
// Ports: i_neg (negate select), i_val (W-bit input), o_val (W-bit output).
module cond_negate #(
  parameter int W = 32
) (
  input  logic         i_neg,
  input  logic [W-1:0] i_val,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/mcycle_unit.sv
// mcycle_unit: multi-cycle shift-add multiply / restoring divide responder.
// Latency: Done in cycle T+WIDTH+1 after a start in cycle T (divide ops finish
//   at T+1 with zero results when MCYCLE_DIV_EN is not defined).
// Backpressure: Busy (combinational in the start cycle) stalls the pipeline.
// Ports: CLK, Reset (sync, active-high), mc (mcycle_unit_if.slave).
// Optional feature: define MCYCLE_DIV_EN to build the divide datapath.
module mcycle_unit
  import mcycle_pkg::*;
#(
  parameter int WIDTH = MC_WIDTH
) (
  input  logic          CLK,
  input  logic          Reset,
  mcycle_unit_if.slave  mc
);

  localparam int CNT_W = mc_cnt_w(WIDTH);
  localparam int W2    = 2 * WIDTH;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  mc_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  // Mul: {partial product, multiplier being shifted out}.
  // Div: {partial remainder, dividend shifting into quotient}.
  logic [W2-1:0]    r_acc;
  // Multiplicand magnitude (mul) or divisor magnitude (div).
  logic [WIDTH-1:0] r_opb;
  // Product / quotient sign: operand signs differ on a signed op.
  logic             r_neg_res;
  logic [WIDTH-1:0] r_res1;
  logic [WIDTH-1:0] r_res2;
  logic             r_done;
`ifdef MCYCLE_DIV_EN
  logic             r_is_div;
  logic             r_rem_neg;
  logic             r_div0;
`endif

  // ---------------------------------------------------------------------------
  // Start-cycle decode and operand magnitudes
  // ---------------------------------------------------------------------------
  logic             w_is_div_op;
  logic             w_signed_op;
  logic             w_neg1;
  logic             w_neg2;
  logic [WIDTH-1:0] w_mag1;
  logic [WIDTH-1:0] w_mag2;
  logic [W2-1:0]    w_acc_init;
  logic [WIDTH-1:0] w_opb_init;
  logic             w_fast_done;
  logic             w_last;

  assign w_is_div_op = mc_is_div(mc.MCycleOp);
  assign w_signed_op = mc_is_signed(mc.MCycleOp);
  assign w_neg1      = w_signed_op & mc.Operand1[WIDTH-1];
  assign w_neg2      = w_signed_op & mc.Operand2[WIDTH-1];
  assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));

  cond_negate #(.W(WIDTH)) u_mag1 (
    .i_neg (w_neg1),
    .i_val (mc.Operand1),
    .o_val (w_mag1)
  );

  cond_negate #(.W(WIDTH)) u_mag2 (
    .i_neg (w_neg2),
    .i_val (mc.Operand2),
    .o_val (w_mag2)
  );

  always_comb begin
    // Multiply: multiplier sits in the low half and is consumed LSB first.
    w_acc_init = {{WIDTH{1'b0}}, w_mag2};
    w_opb_init = w_mag1;
`ifdef MCYCLE_DIV_EN
    // Divide: dividend sits in the low half and is consumed MSB first.
    if (w_is_div_op) begin
      w_acc_init = {{WIDTH{1'b0}}, w_mag1};
      w_opb_init = w_mag2;
    end
`endif
  end

`ifdef MCYCLE_DIV_EN
  assign w_fast_done = 1'b0;
`else
  // Without divide hardware a divide op skips COMPUTE entirely.
  assign w_fast_done = w_is_div_op;
`endif

  // ---------------------------------------------------------------------------
  // Per-iteration datapath
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   w_mul_hi;
  logic [W2-1:0]    w_mul_nxt;
  logic [W2-1:0]    w_prod;
  logic [W2-1:0]    w_acc_nxt;
  logic [WIDTH-1:0] w_res1;
  logic [WIDTH-1:0] w_res2;

  // Add multiplicand into the high half when the current multiplier bit is
  // set, then shift the whole accumulator right by one (carry included).
  assign w_mul_hi  = {1'b0, r_acc[W2-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
  assign w_mul_nxt = {w_mul_hi, r_acc[WIDTH-1:1]};

  // Sign fix is applied to the value being written on the final iteration.
  cond_negate #(.W(W2)) u_prod_sign (
    .i_neg (r_neg_res),
    .i_val (w_mul_nxt),
    .o_val (w_prod)
  );

`ifdef MCYCLE_DIV_EN
  logic [WIDTH:0]   w_trial;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [W2-1:0]    w_div_nxt;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;

  // Shift the next dividend bit into the partial remainder and try the
  // subtraction; keep it only when it does not go negative.
  assign w_trial   = r_acc[W2-1:WIDTH-1];
  assign w_diff    = w_trial - {1'b0, r_opb};
  assign w_ge      = (w_trial >= {1'b0, r_opb});
  assign w_div_nxt = {(w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0]),
                      r_acc[WIDTH-2:0], w_ge};

  cond_negate #(.W(WIDTH)) u_quo_sign (
    .i_neg (r_neg_res),
    .i_val (w_div_nxt[WIDTH-1:0]),
    .o_val (w_quo)
  );

  cond_negate #(.W(WIDTH)) u_rem_sign (
    .i_neg (r_rem_neg),
    .i_val (w_div_nxt[W2-1:WIDTH]),
    .o_val (w_rem)
  );
`endif

  always_comb begin
    w_acc_nxt = w_mul_nxt;
    w_res1    = w_prod[WIDTH-1:0];
    w_res2    = w_prod[W2-1:WIDTH];
`ifdef MCYCLE_DIV_EN
    if (r_is_div) begin
      w_acc_nxt = w_div_nxt;
      // A zero divisor already yields an all-ones magnitude quotient and the
      // dividend as remainder; only the quotient sign fix must be bypassed.
      w_res1    = r_div0 ? '1 : w_quo;
      w_res2    = w_rem;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // FSM with registered results and Done
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state   <= MC_IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opb     <= '0;
      r_neg_res <= 1'b0;
      r_res1    <= '0;
      r_res2    <= '0;
      r_done    <= 1'b0;
`ifdef MCYCLE_DIV_EN
      r_is_div  <= 1'b0;
      r_rem_neg <= 1'b0;
      r_div0    <= 1'b0;
`endif
    end else begin
      case (r_state)
        MC_IDLE, MC_DONE: begin
          r_done <= 1'b0;
          if (mc.MStart) begin
            if (w_fast_done) begin
              r_state <= MC_DONE;
              r_done  <= 1'b1;
              r_res1  <= '0;
              r_res2  <= '0;
            end else begin
              r_state   <= MC_COMPUTE;
              r_cnt     <= '0;
              r_acc     <= w_acc_init;
              r_opb     <= w_opb_init;
              r_neg_res <= w_neg1 ^ w_neg2;
`ifdef MCYCLE_DIV_EN
              r_is_div  <= w_is_div_op;
              r_rem_neg <= w_neg1;
              r_div0    <= (mc.Operand2 == '0);
`endif
            end
          end else begin
            r_state <= MC_IDLE;
          end
        end

        MC_COMPUTE: begin
          // MStart is deliberately not looked at here.
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_state <= MC_DONE;
            r_done  <= 1'b1;
            r_res1  <= w_res1;
            r_res2  <= w_res2;
          end
        end

        default: begin
          r_state <= MC_IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Busy must rise in the start cycle itself so the stall is not late.
  assign mc.Busy    = (mc.MStart & (r_state != MC_COMPUTE)) | (r_state == MC_COMPUTE);
  assign mc.Done    = r_done;
  assign mc.Result1 = r_res1;
  assign mc.Result2 = r_res2;

endmodule

// File: tb/tb_mcycle_unit.sv
// tb_mcycle_unit: table-driven and scoreboard-checked bench for mcycle_unit.
// Expected results are queued at start and compared when Done is seen.
// Divide expectations follow whether MCYCLE_DIV_EN is defined.
module tb_mcycle_unit;
  import mcycle_pkg::*;

  localparam int W = 32;
`ifdef MCYCLE_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic Reset;
  always #5 CLK = ~CLK;

  mcycle_unit_if #(.WIDTH(W)) mc_if ();

  mcycle_unit #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .mc    (mc_if.slave)
  );

  int n_total  = 0;
  int n_bad    = 0;
  int done_cnt = 0;
  logic [63:0] sb[$];
  logic [63:0] mon_exp;

  typedef struct {
    string       name;
    mc_op_t      op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic is_div(input mc_op_t op);
    return (op == MC_DIVU) || (op == MC_DIVS);
  endfunction

  function automatic int lat_of(input mc_op_t op);
    return (is_div(op) && !DIV_EN) ? 1 : W + 1;
  endfunction

  // Behavioural reference: returns {Result1, Result2}.
  function automatic logic [63:0] model(input mc_op_t op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int sa;
    int sbv;
    sa  = a;
    sbv = b;
    case (op)
      MC_MULU: p = {32'h0, a} * {32'h0, b};
      MC_MULS: p = longint'(sa) * longint'(sbv);
      default: p = '0;
    endcase
    if (!is_div(op)) return {p[31:0], p[63:32]};
    if (!DIV_EN) return 64'h0;
    if (op == MC_DIVU) return {a / b, a % b};
    return {32'(sa / sbv), 32'(sa % sbv)};
  endfunction

  // Scoreboard: every Done pops one expected result pair.
  always @(negedge CLK) begin
    if (mc_if.Done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL spurious_done: got Done=1 (R1=%h R2=%h), want no Done",
                 mc_if.Result1, mc_if.Result2);
      end else begin
        mon_exp = sb.pop_front();
        check("result1", {32'h0, mc_if.Result1}, {32'h0, mon_exp[63:32]});
        check("result2", {32'h0, mc_if.Result2}, {32'h0, mon_exp[31:0]});
      end
    end
  end

  task automatic start_op(input string name, input mc_op_t op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] e1, input logic [31:0] e2);
    mc_if.MStart   = 1'b1;
    mc_if.MCycleOp = op;
    mc_if.Operand1 = a;
    mc_if.Operand2 = b;
    sb.push_back({e1, e2});
    #1;
    check({name, "_busy_start"}, {63'h0, mc_if.Busy}, 64'h1);
  endtask

  // Runs cycles after a start until Done; optionally pulses MStart (2x2) at
  // cycle poke_at, which must be ignored.
  task automatic wait_done(input string name, input int exp_lat, input int poke_at);
    int k;
    bit busy_ok;
    k       = 0;
    busy_ok = 1'b1;
    do begin
      tick();
      k++;
      mc_if.MStart = (k == poke_at);
      if (k == poke_at) begin
        mc_if.Operand1 = 32'd2;
        mc_if.Operand2 = 32'd2;
      end
      #1;
      if (mc_if.Done !== 1'b1 && mc_if.Busy !== 1'b1) busy_ok = 1'b0;
    end while (mc_if.Done !== 1'b1 && k < 60);
    check({name, "_latency"}, 64'(k), 64'(exp_lat));
    check({name, "_busy_hold"}, {63'h0, busy_ok}, 64'h1);
    if (poke_at == 0)
      check({name, "_busy_at_done"}, {63'h0, mc_if.Busy}, 64'h0);
  endtask

  initial begin
    int base;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [63:0] m;
    mc_op_t op;

    vecs[0]  = '{"mulu_max",  MC_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE};
    vecs[1]  = '{"muls_neg",  MC_MULS, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 32'hFFFFFFFF};
    vecs[2]  = '{"divu_100_7", MC_DIVU, 32'd100,     32'd7,        32'd14,       32'd2};
    vecs[3]  = '{"divs_m7_2", MC_DIVS, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF};
    vecs[4]  = '{"divu_by0",  MC_DIVU, 32'h00001234, 32'h0,        32'hFFFFFFFF, 32'h00001234};
    vecs[5]  = '{"divs_ovf",  MC_DIVS, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0};
    vecs[6]  = '{"muls_min",  MC_MULS, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000};
    vecs[7]  = '{"divs_7_m2", MC_DIVS, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1};
    vecs[8]  = '{"muls_m1m1", MC_MULS, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h0};
    vecs[9]  = '{"divs_by0",  MC_DIVS, 32'hFFFFEDCC, 32'h0,        32'hFFFFFFFF, 32'hFFFFEDCC};
    vecs[10] = '{"mulu_zero", MC_MULU, 32'h0,        32'd5,        32'h0,        32'h0};
    vecs[11] = '{"mulu_mix",  MC_MULU, 32'h00010000, 32'h00030001, 32'h00010000, 32'h00000003};

    Reset          = 1'b1;
    mc_if.MStart   = 1'b0;
    mc_if.MCycleOp = MC_MULU;
    mc_if.Operand1 = '0;
    mc_if.Operand2 = '0;
    repeat (3) tick();
    Reset = 1'b0;
    #1;
    check("rst_result1", {32'h0, mc_if.Result1}, 64'h0);
    check("rst_result2", {32'h0, mc_if.Result2}, 64'h0);
    check("rst_busy",    {63'h0, mc_if.Busy},    64'h0);
    check("rst_done",    {63'h0, mc_if.Done},    64'h0);

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      e1 = vecs[i].e1;
      e2 = vecs[i].e2;
      if (is_div(vecs[i].op) && !DIV_EN) begin
        e1 = '0;
        e2 = '0;
      end
      tick();
      start_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, e1, e2);
      wait_done(vecs[i].name, lat_of(vecs[i].op), 0);
    end

    // Random operands against the behavioural model.
    for (int i = 0; i < 8; i++) begin
      op = mc_op_t'(2'(i));
      a  = $urandom;
      b  = $urandom;
      if (is_div(op)) begin
        b = $urandom_range(1, 65535);
        if (op == MC_DIVS && $urandom_range(0, 1) == 1) b = -b;
      end
      m = model(op, a, b);
      tick();
      start_op("rand", op, a, b, m[63:32], m[31:0]);
      wait_done("rand", lat_of(op), 0);
    end

    // Second start while computing must be ignored: one Done, result 42.
    tick();
    base = done_cnt;
    start_op("ignored", MC_MULU, 32'd6, 32'd7, 32'd42, 32'd0);
    wait_done("ignored", W + 1, 5);
    repeat (5) tick();
    check("ignored_done_count", 64'(done_cnt - base), 64'd1);

    // Reset in the middle of an operation discards it.
    tick();
    base = done_cnt;
    start_op("rst_mid", MC_MULU, 32'd6, 32'd7, 32'd42, 32'd0);
    sb.delete();
    for (int k = 1; k < 10; k++) begin
      tick();
      mc_if.MStart = 1'b0;
    end
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    #1;
    check("rst_mid_busy",    {63'h0, mc_if.Busy},    64'h0);
    check("rst_mid_result1", {32'h0, mc_if.Result1}, 64'h0);
    check("rst_mid_result2", {32'h0, mc_if.Result2}, 64'h0);
    check("rst_mid_done",    {63'h0, mc_if.Done},    64'h0);
    repeat (40) tick();
    check("rst_mid_no_done", 64'(done_cnt - base), 64'd0);

    // Back-to-back: new start in the DONE cycle.
    tick();
    start_op("b2b_first", MC_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE);
    wait_done("b2b_first", W + 1, 0);
    start_op("b2b_second", MC_MULS, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 32'hFFFFFFFF);
    check("b2b_done_with_start", {63'h0, mc_if.Done}, 64'h1);
    wait_done("b2b_second", W + 1, 0);
    repeat (3) tick();
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mcycle_unit.md
# mcycle_unit

Multi-cycle multiply/divide responder on the execute-stage start interface. It accepts a one-cycle start request already gated by the condition check, iterates over the operands, and returns two 32-bit results. It drives `Busy` so the hazard unit stalls the pipeline until the result is ready.

## Interface
- `WIDTH`, default 32: operand and result width; iteration count equals `WIDTH`.
- `CLK`  in  1  clock; all state updates on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `MStart`  in  1  start request, already condition-qualified by the condition check.
- `MCycleOp`  in  2  operation: 00 unsigned mul, 01 signed mul, 10 unsigned div, 11 signed div.
- `Operand1`  in  WIDTH  multiplicand or dividend.
- `Operand2`  in  WIDTH  multiplier or divisor.
- `Result1`  out  WIDTH  product low half, or quotient.
- `Result2`  out  WIDTH  product high half, or remainder.
- `Busy`  out  1  stall request.
- `Done`  out  1  one-cycle pulse; results valid.

## Operation
- States:
  - IDLE: entered on reset.
  - COMPUTE: counter runs 0..WIDTH-1.
  - DONE: lasts exactly one cycle.
- Transitions:
  - IDLE or DONE with `MStart`=1 → COMPUTE. Capture op, operand magnitudes, and result sign flags; counter cleared.
  - COMPUTE with counter = WIDTH-1 → DONE.
  - DONE with `MStart`=0 → IDLE.
- `MStart` in COMPUTE is ignored. Operands and op are not resampled.
- Multiply:
  - Shift-add, one partial product per cycle, on a 2×WIDTH accumulator.
  - Signed ops multiply magnitudes, then two's-complement the 2×WIDTH product when the operand signs differ.
- Divide:
  - Restoring division, one quotient bit per cycle.
  - Signed quotient is negated when the operand signs differ.
  - Signed remainder takes the dividend's sign.
- Divide by zero: `Result1` = all ones, `Result2` = `Operand1`. Latency is unchanged.
- Signed overflow, 0x80000000 / -1: `Result1` = 0x80000000, `Result2` = 0. This falls out of magnitude arithmetic; no special case is needed.
- Result registers:
  - Written only on the COMPUTE→DONE edge.
  - Hold their value through IDLE until the next completion.
- Reset (any state, including mid-COMPUTE):
  - Next state IDLE.
  - `Result1` = `Result2` = 0, `Busy` = 0, `Done` = 0.
  - Any in-flight operation is discarded and produces no `Done`.

## Timing
- Start cycle T: `MStart`=1 in IDLE or DONE.
  - `Busy`=1 combinationally in cycle T, so the stall takes effect in the same cycle.
  - Operands are captured at the end of T.
- Cycles T+1 .. T+WIDTH: COMPUTE, `Busy`=1.
- Cycle T+WIDTH+1: DONE, `Busy`=0, `Done`=1, results valid. The stage consumes them in this cycle.
- Total stall is WIDTH+1 cycles; T+33 for WIDTH=32.
- `Busy` = (`MStart` & (IDLE | DONE)) | COMPUTE.
- Back-to-back: `MStart` in the DONE cycle starts a new op. `Done` and `Busy` are both 1 in that cycle.

## Configuration
- `MCYCLE_DIV_EN` defined: divide datapath present; ops 10 and 11 behave as above.
- `MCYCLE_DIV_EN` undefined:
  - Divide hardware is omitted.
  - For ops 10 and 11, `Busy` is asserted only in the start cycle.
  - DONE follows in the next cycle with `Result1` = `Result2` = 0.
  - Multiply ops are unaffected.

## Structure
- Shared package `mcycle_pkg` holds:
  - op codes `MC_MULU`, `MC_MULS`, `MC_DIVU`, `MC_DIVS`;
  - state encodings `MC_IDLE`, `MC_COMPUTE`, `MC_DONE`;
  - the iteration-counter width, $clog2(`WIDTH`).
- One sub-module, `cond_negate`: parameterised-width conditional two's complement. It is instantiated for:
  - input magnitudes;
  - product sign fix;
  - quotient sign fix;
  - remainder sign fix.

## Test plan
- Unsigned mul, 0xFFFFFFFF × 0xFFFFFFFF → `Result1`=0x00000001, `Result2`=0xFFFFFFFE. `Busy` high T..T+32, `Done` at T+33.
- Signed mul, -3 × 7 → `Result1`=0xFFFFFFEB, `Result2`=0xFFFFFFFF.
- Division:
  - Unsigned 100 / 7 → `Result1`=14, `Result2`=2.
  - Signed -7 / 2 → `Result1`=0xFFFFFFFD, `Result2`=0xFFFFFFFF.
- Boundary divides:
  - 0x1234 / 0 → `Result1`=0xFFFFFFFF, `Result2`=0x1234.
  - Signed 0x80000000 / 0xFFFFFFFF → `Result1`=0x80000000, `Result2`=0.
- Ignored start:
  - Start 6×7, then pulse `MStart` at T+5 with 2×2 → first result 42 only; a single `Done`.
- Reset mid-operation:
  - Assert `Reset` at T+10 → `Busy`=0 and results 0 from T+11; no `Done` follows.
- Back-to-back:
  - `MStart` in the DONE cycle → `Busy`=1 that cycle.
  - The second `Done` arrives 33 cycles later with the correct second result.
